// File: rtl/uart_bus_pkg.sv
// Shared constants and state encoding for the UART-driven bus initiator.
package uart_bus_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    TX_LOAD,
    TX_WAIT
  } state_t;

endpackage

// File: rtl/uart_bus_master_byte_serializer.sv
// Sends a 1- or 4-byte response MSB first, one tx_start per byte, gated by tx_busy.
module byte_serializer
  import uart_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  input  logic [2:0]  count,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);

  state_t      st, st_n;
  logic [31:0] sh;
  logic [2:0]  rem;
  logic        fire;

  assign fire = (st == TX_LOAD) && !tx_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= IDLE;
      sh  <= 32'h0;
      rem <= 3'd0;
    end else begin
      st <= st_n;
      if (start && st == IDLE) begin
        sh  <= word;
        rem <= count;
      end else if (fire) begin
        sh  <= {sh[23:0], 8'h00};
        rem <= rem - 3'd1;
      end
    end
  end

  always_comb begin
    st_n = st;
    case (st)
      IDLE:    if (start) st_n = TX_LOAD;
      TX_LOAD: if (fire) st_n = TX_WAIT;
      TX_WAIT: st_n = (rem != 3'd0) ? TX_LOAD : IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    tx_start = fire;
    tx_data  = (st == TX_LOAD) ? sh[31:24] : 8'h00;
    done     = (st == TX_WAIT) && (rem == 3'd0);
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART byte stream to single bus read/write transactions, with byte responses.
// Optional partial-frame timeout: define UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  input  logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        busy
);

  state_t     st, st_n;
  logic [1:0] cnt;
  logic       is_wr;
  logic       op_ok;
  logic       timeout;
  logic       ser_done;

  assign op_ok = rx_valid && (rx_data == OP_READ || rx_data == OP_WRITE);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  logic [31:0] tmo;

  always_ff @(posedge clk) begin
    if (reset)                         tmo <= 32'h0;
    else if (rx_valid)                 tmo <= 32'h0;
    else if (st == ADDR || st == DATA) tmo <= tmo + 32'd1;
    else                               tmo <= 32'h0;
  end

  assign timeout = (st == ADDR || st == DATA) && !rx_valid && (tmo >= TIMEOUT_CYCLES);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= IDLE;
      cnt   <= 2'd0;
      is_wr <= 1'b0;
      addr  <= 32'h0;
      wdata <= 32'h0;
    end else begin
      st <= st_n;
      if (st == IDLE && op_ok) is_wr <= (rx_data == OP_WRITE);
      if (st == ADDR && rx_valid) begin
        addr <= {addr[23:0], rx_data};
        cnt  <= cnt + 2'd1;
      end
      if (st == DATA && rx_valid) begin
        wdata <= {wdata[23:0], rx_data};
        cnt   <= cnt + 2'd1;
      end
      if (timeout) cnt <= 2'd0;
    end
  end

  // TX_LOAD here covers the whole response; the serializer tracks load/wait per byte.
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    if (op_ok) st_n = ADDR;
      ADDR:    if (timeout) st_n = IDLE;
               else if (rx_valid && cnt == 2'd3) st_n = is_wr ? DATA : BUS;
      DATA:    if (timeout) st_n = IDLE;
               else if (rx_valid && cnt == 2'd3) st_n = BUS;
      BUS:     st_n = TX_LOAD;
      TX_LOAD: if (ser_done) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    rd   = (st == BUS) && !is_wr;
    wr   = (st == BUS) && is_wr;
    busy = (st != IDLE);
  end

  byte_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .start    (st == BUS),
    .word     (is_wr ? {ACK_BYTE, 24'h0} : rdata),
    .count    (is_wr ? 3'd1 : 3'd4),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a 10-cycle transmitter busy model.
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic        busy;

  logic [31:0] resp_word;
  logic [3:0]  bcnt;
  int          errors = 0, checks = 0;
  int          rd_cnt = 0, wr_cnt = 0, viol = 0;
  int          cyc = 0, last_tx = -1, min_gap = 1000;
  logic [7:0]  txq[$];
  int          rd0, wr0;

  always #5 clk = ~clk;

  uart_bus_master #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .rdata(rdata), .tx_data(tx_data), .tx_start(tx_start),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .busy(busy)
  );

  assign rdata   = rd ? resp_word : 32'hDEADBEEF;
  assign tx_busy = (bcnt != 4'd0);

  always @(posedge clk) begin
    if (tx_start)          bcnt <= 4'd10;
    else if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
  end

  initial begin
    bcnt = 4'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd) rd_cnt++;
      if (wr) wr_cnt++;
      if (tx_start) begin
        txq.push_back(tx_data);
        if (tx_busy) viol++;
        if (last_tx >= 0 && cyc - last_tx < min_gap) min_gap = cyc - last_tx;
        last_tx = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8]);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk(tag, busy, 1'b0);
  endtask

  task automatic chk_resp(input string tag, input int n, input logic [31:0] w);
    chk({tag, "_ntx"}, txq.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), txq[i], w[31-8*i -: 8]);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] d);
    resp_word = d;
    txq.delete();
    rd0 = rd_cnt;
    send(8'h52);
    send_word(a);
    chk({tag, "_rd"}, rd, 1'b1);
    chk({tag, "_addr"}, addr, a);
    chk({tag, "_notx"}, tx_start, 1'b0);
    @(negedge clk);
    chk({tag, "_rd_1cyc"}, rd, 1'b0);
    wait_idle({tag, "_idle"});
    chk({tag, "_rd_cnt"}, rd_cnt - rd0, 1);
    chk_resp(tag, 4, d);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; resp_word = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_rd", rd, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_txs", tx_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_txd", tx_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // write frame
    txq.delete();
    wr0 = wr_cnt;
    send(8'h57);
    chk("wr_busy_rise", busy, 1'b1);
    send_word(32'h4000000C);
    send_word(32'h000000A5);
    chk("wr_strobe", wr, 1'b1);
    chk("wr_rd_low", rd, 1'b0);
    chk("wr_addr", addr, 32'h4000000C);
    chk("wr_wdata", wdata, 32'h000000A5);
    @(negedge clk);
    chk("wr_1cyc", wr, 1'b0);
    wait_idle("wr_idle");
    chk("wr_cnt", wr_cnt - wr0, 1);
    chk_resp("wr_ack", 1, 32'h4B000000);
    chk("wr_addr_hold", addr, 32'h4000000C);
    chk("wr_wdata_hold", wdata, 32'h000000A5);

    // read issued in the first cycle busy is low
    do_read("rd1", 32'h40000010, 32'h000000F3);
    chk("rd1_viol", viol, 0);
    chk("rd1_gap", min_gap >= 2, 1'b1);

    // bad opcode then a read
    txq.delete();
    send(8'h00);
    chk("bad_op_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("bad_op_notx", txq.size(), 0);
    do_read("rd2", 32'h12345678, 32'hCAFEF00D);

    // stray byte during a response
    resp_word = 32'h11223344;
    txq.delete();
    rd0 = rd_cnt;
    send(8'h52);
    send_word(32'h00000004);
    repeat (4) @(negedge clk);
    send(8'hFF);
    wait_idle("ff_idle");
    chk_resp("ff", 4, 32'h11223344);
    chk("ff_addr", addr, 32'h00000004);
    repeat (3) @(negedge clk);
    chk("ff_no_frame", busy, 1'b0);
    chk("ff_rd_cnt", rd_cnt - rd0, 1);

    // reset mid-frame
    rd0 = rd_cnt;
    send(8'h52); send(8'h40); send(8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_addr", addr, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_mid_nord", rd_cnt - rd0, 0);
    do_read("rd3", 32'h00000020, 32'hA5A55A5A);

    // partial frame then idle
    rd0 = rd_cnt;
    send(8'h52); send(8'h40); send(8'h00);
    repeat (20) @(negedge clk);
    chk("tmo_nord", rd_cnt - rd0, 0);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    chk("tmo_idle", busy, 1'b0);
    do_read("tmo_rd", 32'h40000008, 32'h00000077);
`else
    chk("notmo_wait", busy, 1'b1);
    resp_word = 32'h00000077;
    txq.delete();
    send(8'h00); send(8'h08);
    chk("notmo_rd", rd, 1'b1);
    chk("notmo_addr", addr, 32'h40000008);
    wait_idle("notmo_idle");
    chk_resp("notmo", 4, 32'h00000077);
`endif

    chk("final_viol", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
